// File: rtl/ic_miss_tracker.sv
// Instruction-cache miss tracker: merges duplicate line misses, issues DRAM reads
// round-robin through a held valid/ready register, and retires fills by slot ID.
module ic_miss_tracker #(
  parameter  int N_MTX  = 4,
  parameter  int ADDR_W = 23,
  localparam int XID_W  = $clog2(N_MTX),
  localparam int CNT_W  = $clog2(N_MTX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XID_W-1:0]  mem_xid,
  input  logic              mem_ready,
  input  logic              fill_valid,
  input  logic [XID_W-1:0]  fill_xid,
  output logic              fill_wb,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              fill_err,
  input  logic              flush,
  output logic              busy,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic [1:0] {FREE, PEND, ISSUED, DISCARD} slot_st_t;

  slot_st_t          st_q   [N_MTX];
  slot_st_t          st_d   [N_MTX];
  logic [ADDR_W-1:0] addr_q [N_MTX];
  logic [ADDR_W-1:0] addr_d [N_MTX];
  logic [N_MTX-1:0]  kill_q, kill_d;
  logic [XID_W-1:0]  rr_ptr;

  logic              xid_ok, fill_live;
  logic [XID_W-1:0]  fill_idx;
  logic              hit, free_found, alloc;
  logic [XID_W-1:0]  free_idx;
  logic              hs, load;
  logic              cand_found;
  logic [XID_W-1:0]  cand_idx, scan_idx;
  logic [XID_W:0]    scan_sum;
  logic [CNT_W-1:0]  cnt_d;

  // Out-of-range IDs (non power-of-two N_MTX) are treated like fills to a FREE slot.
  always_comb begin
    xid_ok    = {1'b0, fill_xid} < (XID_W+1)'(N_MTX);
    fill_idx  = xid_ok ? fill_xid : '0;
    fill_live = fill_valid && xid_ok &&
                (st_q[fill_idx] == ISSUED || st_q[fill_idx] == DISCARD);
    fill_wb   = fill_valid && xid_ok && (st_q[fill_idx] == ISSUED);
    fill_addr = addr_q[fill_idx];
  end

  always_comb begin
    hit        = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < N_MTX; i++) begin
      if ((st_q[i] == PEND || st_q[i] == ISSUED) && addr_q[i] == miss_addr)
        hit = 1'b1;
      if (!free_found && st_q[i] == FREE) begin
        free_found = 1'b1;
        free_idx   = XID_W'(i);
      end
    end
    miss_ready = miss_valid && !flush && (hit || free_found);
    alloc      = miss_ready && !hit;
  end

  // Round-robin scan from rr_ptr; under flush every unpresented PEND slot dies, so none qualify.
  always_comb begin
    hs         = mem_re && mem_ready;
    load       = !mem_re || mem_ready;
    cand_found = 1'b0;
    cand_idx   = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int k = 0; k < N_MTX; k++) begin
      scan_sum = {1'b0, rr_ptr} + (XID_W+1)'(k);
      if (scan_sum >= (XID_W+1)'(N_MTX))
        scan_sum = scan_sum - (XID_W+1)'(N_MTX);
      scan_idx = scan_sum[XID_W-1:0];
      if (!cand_found && !flush && st_q[scan_idx] == PEND &&
          !(mem_re && mem_xid == scan_idx)) begin
        cand_found = 1'b1;
        cand_idx   = scan_idx;
      end
    end
  end

  // Fill retirement has priority, then handshake, flush and finally allocation.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N_MTX; i++) begin
      st_d[i]   = st_q[i];
      addr_d[i] = addr_q[i];
      kill_d[i] = kill_q[i];
      if (fill_live && fill_idx == XID_W'(i)) begin
        st_d[i] = FREE;
      end else if (hs && mem_xid == XID_W'(i)) begin
        st_d[i]   = (kill_q[i] || flush) ? DISCARD : ISSUED;
        kill_d[i] = 1'b0;
      end else if (flush) begin
        if (st_q[i] == ISSUED)
          st_d[i] = DISCARD;
        else if (st_q[i] == PEND) begin
          if (mem_re && mem_xid == XID_W'(i))
            kill_d[i] = 1'b1;
          else
            st_d[i] = FREE;
        end
      end else if (alloc && free_idx == XID_W'(i)) begin
        st_d[i]   = PEND;
        addr_d[i] = miss_addr;
        kill_d[i] = 1'b0;
      end
      if (st_d[i] != FREE)
        cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_MTX; i++) begin
        st_q[i]   <= FREE;
        addr_q[i] <= '0;
      end
      kill_q   <= '0;
      rr_ptr   <= '0;
      mem_re   <= 1'b0;
      mem_addr <= '0;
      mem_xid  <= '0;
      fill_err <= 1'b0;
      busy     <= 1'b0;
      count    <= '0;
    end else begin
      for (int i = 0; i < N_MTX; i++) begin
        st_q[i]   <= st_d[i];
        addr_q[i] <= addr_d[i];
      end
      kill_q <= kill_d;
      if (hs)
        rr_ptr <= (mem_xid == XID_W'(N_MTX - 1)) ? '0 : mem_xid + XID_W'(1);
      if (load) begin
        mem_re <= cand_found;
        if (cand_found) begin
          mem_addr <= addr_q[cand_idx];
          mem_xid  <= cand_idx;
        end
      end
      fill_err <= fill_valid && !fill_live;
      busy     <= (cnt_d != '0);
      count    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ic_miss_tracker.sv
// Scoreboard bench for ic_miss_tracker: a 4-slot/23-bit instance and an 8-slot/20-bit instance.
module tb_ic_miss_tracker;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_miss_valid, a_miss_ready, a_mem_re, a_mem_ready;
  logic [22:0] a_miss_addr, a_mem_addr, a_fill_addr;
  logic [1:0]  a_mem_xid, a_fill_xid;
  logic        a_fill_valid, a_fill_wb, a_fill_err, a_flush, a_busy;
  logic [2:0]  a_count;

  logic        b_miss_valid, b_miss_ready, b_mem_re, b_mem_ready;
  logic [19:0] b_miss_addr, b_mem_addr, b_fill_addr;
  logic [2:0]  b_mem_xid, b_fill_xid;
  logic        b_fill_valid, b_fill_wb, b_fill_err, b_flush, b_busy;
  logic [3:0]  b_count;

  ic_miss_tracker #(.N_MTX(4), .ADDR_W(23)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(a_miss_valid), .miss_addr(a_miss_addr), .miss_ready(a_miss_ready),
    .mem_re(a_mem_re), .mem_addr(a_mem_addr), .mem_xid(a_mem_xid), .mem_ready(a_mem_ready),
    .fill_valid(a_fill_valid), .fill_xid(a_fill_xid), .fill_wb(a_fill_wb),
    .fill_addr(a_fill_addr), .fill_err(a_fill_err), .flush(a_flush),
    .busy(a_busy), .count(a_count)
  );

  ic_miss_tracker #(.N_MTX(8), .ADDR_W(20)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(b_miss_valid), .miss_addr(b_miss_addr), .miss_ready(b_miss_ready),
    .mem_re(b_mem_re), .mem_addr(b_mem_addr), .mem_xid(b_mem_xid), .mem_ready(b_mem_ready),
    .fill_valid(b_fill_valid), .fill_xid(b_fill_xid), .fill_wb(b_fill_wb),
    .fill_addr(b_fill_addr), .fill_err(b_fill_err), .flush(b_flush),
    .busy(b_busy), .count(b_count)
  );

  typedef struct {
    logic [22:0] addr;
    logic [3:0]  xid;
  } req_t;

  req_t exp_q[$];
  req_t exp_r;
  int   errors = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_mem_re, a_mem_addr, a_mem_xid, a_fill_err, a_busy, a_count, a_miss_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_a: got re=%0b addr=%h xid=%0d err=%0b busy=%0b count=%0d, want all 0",
               a_mem_re, a_mem_addr, a_mem_xid, a_fill_err, a_busy, a_count);
    end
    checks++;
    if ({b_mem_re, b_mem_addr, b_mem_xid, b_fill_err, b_busy, b_count} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_b: got re=%0b count=%0d busy=%0b, want 0", b_mem_re, b_count, b_busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [22:0] miss_list [2];
    logic [9:0]  re_pattern;
    int          sent;
    miss_list[0] = 23'h100;
    miss_list[1] = 23'h200;
    re_pattern   = 10'b00_0000_1100;
    sent         = 0;
    a_mem_ready  = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      checks++;
      if (a_mem_re !== re_pattern[cyc]) begin
        errors++;
        $display("[TB] FAIL b2b_mem_re cyc%0d: got %0b want %0b", cyc, a_mem_re, re_pattern[cyc]);
      end
      if (a_mem_re && a_mem_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_req: got unexpected xid=%0d, want no request", a_mem_xid);
        end else begin
          exp_r = exp_q.pop_front();
          if (a_mem_addr !== exp_r.addr || a_mem_xid !== exp_r.xid[1:0]) begin
            errors++;
            $display("[TB] FAIL b2b_req: got addr=%h xid=%0d want addr=%h xid=%0d",
                     a_mem_addr, a_mem_xid, exp_r.addr, exp_r.xid);
          end
        end
      end
      if (sent < 2) begin
        a_miss_valid = 1'b1;
        a_miss_addr  = miss_list[sent];
        #1;
        checks++;
        if (a_miss_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_miss_ready%0d: got %0b want 1", sent, a_miss_ready);
        end
        exp_r.addr = miss_list[sent];
        exp_r.xid  = 4'(sent);
        exp_q.push_back(exp_r);
        sent++;
      end else begin
        a_miss_valid = 1'b0;
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_all_issued: got %0d outstanding want 0", exp_q.size());
    end
    exp_q.delete();
    a_fill_valid = 1'b1;
    a_fill_xid   = 2'd1;
    #1;
    checks++;
    if (a_fill_wb !== 1'b1 || a_fill_addr !== 23'h200) begin
      errors++;
      $display("[TB] FAIL b2b_fill: got wb=%0b addr=%h want wb=1 addr=200", a_fill_wb, a_fill_addr);
    end
    checks++;
    if (a_count !== 3'd2) begin
      errors++;
      $display("[TB] FAIL b2b_count_before: got %0d want 2", a_count);
    end
    tick();
    a_fill_valid = 1'b0;
    checks++;
    if (a_count !== 3'd1 || a_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_count_after: got count=%0d busy=%0b want 1/1", a_count, a_busy);
    end
  endtask

  task automatic test_merge();
    a_miss_valid = 1'b1;
    a_miss_addr  = 23'h100;
    #1;
    checks++;
    if (a_miss_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL merge_ready: got %0b want 1", a_miss_ready);
    end
    tick();
    a_miss_valid = 1'b0;
    checks++;
    if (a_count !== 3'd1) begin
      errors++;
      $display("[TB] FAIL merge_count: got %0d want 1", a_count);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (a_mem_re !== 1'b0) begin
        errors++;
        $display("[TB] FAIL merge_no_req%0d: got mem_re=%0b want 0", c, a_mem_re);
      end
      tick();
    end
    a_fill_valid = 1'b1;
    a_fill_xid   = 2'd0;
    #1;
    checks++;
    if (a_fill_wb !== 1'b1 || a_fill_addr !== 23'h100) begin
      errors++;
      $display("[TB] FAIL merge_fill: got wb=%0b addr=%h want 1/100", a_fill_wb, a_fill_addr);
    end
    tick();
    a_fill_valid = 1'b0;
    checks++;
    if (a_count !== 3'd0 || a_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL merge_empty: got count=%0d busy=%0b want 0/0", a_count, a_busy);
    end
  endtask

  task automatic test_stall();
    a_mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_miss_valid = 1'b1;
      a_miss_addr  = 23'h300 + 23'(i * 'h100);
      #1;
      checks++;
      if (a_miss_ready !== (i < 4)) begin
        errors++;
        $display("[TB] FAIL stall_miss_ready%0d: got %0b want %0b", i, a_miss_ready, (i < 4));
      end
      if (i < 4) begin
        exp_r.addr = a_miss_addr;
        exp_r.xid  = 4'(i);
        exp_q.push_back(exp_r);
      end
      tick();
    end
    a_miss_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (a_mem_re !== 1'b1 || a_mem_addr !== exp_q[0].addr || a_mem_xid !== exp_q[0].xid[1:0]) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got re=%0b addr=%h xid=%0d want 1/%h/%0d",
                 c, a_mem_re, a_mem_addr, a_mem_xid, exp_q[0].addr, exp_q[0].xid);
      end
      tick();
    end
    checks++;
    if (a_count !== 3'd4 || a_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_count: got count=%0d busy=%0b want 4/1", a_count, a_busy);
    end
  endtask

  task automatic test_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_mem_re !== 1'b0 || a_count !== 3'd0 || a_busy !== 1'b0 || a_mem_xid !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got re=%0b count=%0d busy=%0b xid=%0d want 0",
               a_mem_re, a_count, a_busy, a_mem_xid);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    a_fill_valid = 1'b1;
    a_fill_xid   = 2'd0;
    #1;
    checks++;
    if (a_fill_wb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_wb: got %0b want 0", a_fill_wb);
    end
    tick();
    a_fill_valid = 1'b0;
    checks++;
    if (a_fill_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_err: got %0b want 1", a_fill_err);
    end
    tick();
  endtask

  task automatic test_flush();
    a_mem_ready  = 1'b0;
    a_miss_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_miss_addr = 23'h10 * 23'(i + 1);
      a_mem_ready = (i == 2);
      #1;
      checks++;
      if (a_miss_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL flush_miss%0d: got %0b want 1", i, a_miss_ready);
      end
      if (i < 2) begin
        exp_r.addr = a_miss_addr;
        exp_r.xid  = 4'(i);
        exp_q.push_back(exp_r);
      end
      if (a_mem_re && a_mem_ready) begin
        exp_r = exp_q.pop_front();
        checks++;
        if (a_mem_addr !== exp_r.addr || a_mem_xid !== exp_r.xid[1:0]) begin
          errors++;
          $display("[TB] FAIL flush_req0: got addr=%h xid=%0d want %h/%0d",
                   a_mem_addr, a_mem_xid, exp_r.addr, exp_r.xid);
        end
      end
      tick();
    end
    a_miss_valid = 1'b0;
    a_mem_ready  = 1'b0;
    tick();
    checks++;
    if (a_mem_re !== 1'b1 || a_mem_addr !== exp_q[0].addr || a_mem_xid !== exp_q[0].xid[1:0]) begin
      errors++;
      $display("[TB] FAIL flush_presented: got re=%0b addr=%h xid=%0d want 1/%h/%0d",
               a_mem_re, a_mem_addr, a_mem_xid, exp_q[0].addr, exp_q[0].xid);
    end
    a_flush      = 1'b1;
    a_miss_valid = 1'b1;
    a_miss_addr  = 23'h40;
    #1;
    checks++;
    if (a_miss_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_miss_blocked: got %0b want 0", a_miss_ready);
    end
    tick();
    a_flush      = 1'b0;
    a_miss_valid = 1'b0;
    checks++;
    if (a_count !== 3'd2 || a_mem_re !== 1'b1 || a_mem_xid !== 2'd1) begin
      errors++;
      $display("[TB] FAIL flush_after: got count=%0d re=%0b xid=%0d want 2/1/1", a_count, a_mem_re, a_mem_xid);
    end
    a_mem_ready = 1'b1;
    exp_r = exp_q.pop_front();
    checks++;
    if (a_mem_addr !== exp_r.addr) begin
      errors++;
      $display("[TB] FAIL flush_req1: got addr=%h want %h", a_mem_addr, exp_r.addr);
    end
    tick();
    a_mem_ready = 1'b0;
    checks++;
    if (a_mem_re !== 1'b0 || a_count !== 3'd2) begin
      errors++;
      $display("[TB] FAIL flush_no_reissue: got re=%0b count=%0d want 0/2", a_mem_re, a_count);
    end
    for (int x = 0; x < 2; x++) begin
      a_fill_valid = 1'b1;
      a_fill_xid   = 2'(x);
      #1;
      checks++;
      if (a_fill_wb !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_fill_wb%0d: got %0b want 0", x, a_fill_wb);
      end
      tick();
      checks++;
      if (a_count !== 3'(1 - x) || a_fill_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_drain%0d: got count=%0d err=%0b want %0d/0", x, a_count, a_fill_err, 1 - x);
      end
    end
    a_fill_valid = 1'b0;
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_busy: got %0b want 0", a_busy);
    end
  endtask

  task automatic test_fill_err();
    a_fill_valid = 1'b1;
    a_fill_xid   = 2'd3;
    #1;
    checks++;
    if (a_fill_wb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ferr_wb: got %0b want 0", a_fill_wb);
    end
    tick();
    a_fill_valid = 1'b0;
    checks++;
    if (a_fill_err !== 1'b1 || a_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL ferr_pulse: got err=%0b count=%0d want 1/0", a_fill_err, a_count);
    end
    tick();
    checks++;
    if (a_fill_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ferr_one_cycle: got %0b want 0", a_fill_err);
    end
  endtask

  task automatic test_param8();
    int sent;
    sent        = 0;
    b_mem_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && (sent < 8 || exp_q.size() != 0); cyc++) begin
      if (b_mem_re && b_mem_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL p8_req: got unexpected xid=%0d want none", b_mem_xid);
        end else begin
          exp_r = exp_q.pop_front();
          if (b_mem_addr !== exp_r.addr[19:0] || b_mem_xid !== exp_r.xid[2:0]) begin
            errors++;
            $display("[TB] FAIL p8_req: got addr=%h xid=%0d want %h/%0d",
                     b_mem_addr, b_mem_xid, exp_r.addr, exp_r.xid);
          end
        end
      end
      if (sent < 8) begin
        b_miss_valid = 1'b1;
        b_miss_addr  = 20'h01000 + 20'(sent);
        #1;
        checks++;
        if (b_miss_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL p8_miss%0d: got %0b want 1", sent, b_miss_ready);
        end
        exp_r.addr = 23'(b_miss_addr);
        exp_r.xid  = 4'(sent);
        exp_q.push_back(exp_r);
        sent++;
      end else begin
        b_miss_valid = 1'b0;
      end
      tick();
    end
    checks++;
    if (sent != 8 || exp_q.size() != 0 || b_count !== 4'd8) begin
      errors++;
      $display("[TB] FAIL p8_full: got sent=%0d outstanding=%0d count=%0d want 8/0/8",
               sent, exp_q.size(), b_count);
    end
    b_fill_valid = 1'b1;
    b_fill_xid   = 3'd5;
    b_miss_valid = 1'b1;
    b_miss_addr  = 20'h09000;
    #1;
    checks++;
    if (b_fill_wb !== 1'b1 || b_fill_addr !== 20'h01005 || b_miss_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL p8_fill_miss: got wb=%0b addr=%h ready=%0b want 1/01005/0",
               b_fill_wb, b_fill_addr, b_miss_ready);
    end
    tick();
    b_fill_valid = 1'b0;
    #1;
    checks++;
    if (b_miss_ready !== 1'b1 || b_count !== 4'd7) begin
      errors++;
      $display("[TB] FAIL p8_retry: got ready=%0b count=%0d want 1/7", b_miss_ready, b_count);
    end
    exp_r.addr = 23'h09000;
    exp_r.xid  = 4'd5;
    exp_q.push_back(exp_r);
    tick();
    b_miss_valid = 1'b0;
    checks++;
    if (b_count !== 4'd8) begin
      errors++;
      $display("[TB] FAIL p8_realloc_count: got %0d want 8", b_count);
    end
    tick();
    exp_r = exp_q.pop_front();
    checks++;
    if (b_mem_re !== 1'b1 || b_mem_addr !== exp_r.addr[19:0] || b_mem_xid !== exp_r.xid[2:0]) begin
      errors++;
      $display("[TB] FAIL p8_realloc_req: got re=%0b addr=%h xid=%0d want 1/%h/%0d",
               b_mem_re, b_mem_addr, b_mem_xid, exp_r.addr, exp_r.xid);
    end
    tick();
  endtask

  initial begin
    a_miss_valid = 1'b0; a_miss_addr = '0; a_mem_ready = 1'b0;
    a_fill_valid = 1'b0; a_fill_xid  = '0; a_flush     = 1'b0;
    b_miss_valid = 1'b0; b_miss_addr = '0; b_mem_ready = 1'b0;
    b_fill_valid = 1'b0; b_fill_xid  = '0; b_flush     = 1'b0;
    test_reset();
    test_back_to_back();
    test_merge();
    test_stall();
    test_reset_mid();
    test_flush();
    test_fill_err();
    test_param8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
